// File: rtl/glb_rdport_fetch_pkg.sv
// Shared types and constants for the GLB read-port fetch engine.
package glb_rdport_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  localparam int DEFAULT_FIFO_DEPTH = 4;

  // Credit counters must represent 0..FIFO_DEPTH inclusive.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_CREDIT_W = credit_width(DEFAULT_FIFO_DEPTH);

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO: dout always presents the head entry.
module sync_fifo_sa #(
  parameter int DATA_WIDTH = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       din,
  output logic                        full,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap because depth is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/glb_rdport_fetch.sv
// GLB read-port initiator: strided address generation, credit-limited
// issue and a show-ahead return buffer feeding a compute consumer.
//
// state    | meaning
// ST_IDLE  | waiting for a configuration, CfgRdy high
// ST_ISSUE | sending addresses, gated by return-buffer credit
// ST_DRAIN | all addresses sent, waiting for the last word to be popped
module glb_rdport_fetch
  import glb_rdport_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 256,
  parameter int NUM_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CfgVld,
  output logic                  CfgRdy,
  input  logic [ADDR_WIDTH-1:0] CfgBaseAddr,
  input  logic [ADDR_WIDTH-1:0] CfgStride,
  input  logic [NUM_WIDTH-1:0]  CfgNum,
  output logic [ADDR_WIDTH-1:0] RdPortAddr,
  output logic                  RdPortAddrVld,
  input  logic                  RdPortAddrRdy,
  input  logic [DATA_WIDTH-1:0] RdPortDat,
  input  logic                  RdPortDatVld,
  output logic                  RdPortDatRdy,
  output logic [DATA_WIDTH-1:0] OutDat,
  output logic                  OutDatVld,
  input  logic                  OutDatRdy,
  output logic                  Busy,
  output logic                  Done
);

  localparam int CW = credit_width(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] stride;
  logic [NUM_WIDTH-1:0]  num;
  logic [NUM_WIDTH-1:0]  issued;
  logic [NUM_WIDTH-1:0]  popped;
  logic [NUM_WIDTH-1:0]  issued_next;
  logic [NUM_WIDTH-1:0]  popped_next;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         credit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  cfg_hs;
  logic                  addr_hs;
  logic                  dat_hs;
  logic                  out_hs;

  assign CfgRdy      = (state == ST_IDLE);
  assign Busy        = (state != ST_IDLE);
  assign credit      = inflight + fifo_count;
  // Credit only ever drops while Vld is waiting, so Vld cannot fall without a handshake.
  assign RdPortAddrVld = (state == ST_ISSUE) && (credit < DEPTH_C);
  assign RdPortDatRdy  = ~fifo_full;
  assign OutDatVld     = ~fifo_empty;

  assign cfg_hs  = CfgVld & CfgRdy;
  assign addr_hs = RdPortAddrVld & RdPortAddrRdy;
  assign dat_hs  = RdPortDatVld & RdPortDatRdy;
  assign out_hs  = OutDatVld & OutDatRdy;

  assign issued_next = issued + NUM_WIDTH'(1);
  assign popped_next = popped + NUM_WIDTH'(1);

  sync_fifo_sa #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (dat_hs),
    .din   (RdPortDat),
    .full  (fifo_full),
    .pop   (out_hs),
    .dout  (OutDat),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer: configuration latch, address generator and word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      RdPortAddr <= '0;
      stride     <= '0;
      num        <= '0;
      issued     <= '0;
      popped     <= '0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            if (CfgNum == '0) begin
              Done <= 1'b1;
            end else begin
              state      <= ST_ISSUE;
              RdPortAddr <= CfgBaseAddr;
              stride     <= CfgStride;
              num        <= CfgNum;
              issued     <= '0;
              popped     <= '0;
            end
          end
        end
        ST_ISSUE: begin
          if (addr_hs) begin
            RdPortAddr <= RdPortAddr + stride;
            issued     <= issued_next;
            if (issued_next == num) state <= ST_DRAIN;
          end
          // The final pop cannot land here: its address must already be issued.
          if (out_hs) popped <= popped_next;
        end
        ST_DRAIN: begin
          if (out_hs) begin
            popped <= popped_next;
            if (popped_next == num) begin
              state <= ST_IDLE;
              Done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outstanding GLB requests; the net of issue and return in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({addr_hs, dat_hs})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   if (inflight != '0) inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_glb_rdport_fetch.sv
// Randomised bench for glb_rdport_fetch with a GLB responder and a
// transaction-level model of the expected address and data streams.
module tb_glb_rdport_fetch;

  localparam int AW    = 16;
  localparam int DW    = 256;
  localparam int NW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CfgVld = 1'b0;
  logic          CfgRdy;
  logic [AW-1:0] CfgBaseAddr = '0;
  logic [AW-1:0] CfgStride = '0;
  logic [NW-1:0] CfgNum = '0;
  logic [AW-1:0] RdPortAddr;
  logic          RdPortAddrVld;
  logic          RdPortAddrRdy = 1'b0;
  logic [DW-1:0] RdPortDat = '0;
  logic          RdPortDatVld = 1'b0;
  logic          RdPortDatRdy;
  logic [DW-1:0] OutDat;
  logic          OutDatVld;
  logic          OutDatRdy = 1'b0;
  logic          Busy;
  logic          Done;

  always #5 clk = ~clk;

  glb_rdport_fetch #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_WIDTH  (NW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .CfgVld        (CfgVld),
    .CfgRdy        (CfgRdy),
    .CfgBaseAddr   (CfgBaseAddr),
    .CfgStride     (CfgStride),
    .CfgNum        (CfgNum),
    .RdPortAddr    (RdPortAddr),
    .RdPortAddrVld (RdPortAddrVld),
    .RdPortAddrRdy (RdPortAddrRdy),
    .RdPortDat     (RdPortDat),
    .RdPortDatVld  (RdPortDatVld),
    .RdPortDatRdy  (RdPortDatRdy),
    .OutDat        (OutDat),
    .OutDatVld     (OutDatVld),
    .OutDatRdy     (OutDatRdy),
    .Busy          (Busy),
    .Done          (Done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Test controls.
  int          addr_rdy_mode = 0;   // 0: always ready, 1: random
  int          out_rdy_mode  = 0;   // 0: always ready, 1: held low, 2: random
  int          lat           = 1;
  logic [15:0] salt          = 16'h0;

  function automatic logic [DW-1:0] mk_dat(input logic [AW-1:0] a);
    return {8{a ^ salt, ~a}};
  endfunction

  // Model state: what has happened at the transaction level.
  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } glb_req_t;

  glb_req_t      glbq[$];
  logic [AW-1:0] addr_log[$];
  int            addr_cyc[$];
  int            cyc = 0;
  int            done_cnt = 0;
  bit            m_busy = 0;
  bit            m_done_next = 0;
  int            m_base = 0, m_stride = 0, m_num = 0;
  int            m_issued = 0, m_ret = 0, m_pop = 0;
  bit            prev_stall = 0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    bit            exp_vld;
    bit            addr_hs, dat_hs, out_hs, cfg_hs;
    logic [AW-1:0] exp_a;
    logic [DW-1:0] exp_d;
    if (!rst_n) begin
      glbq.delete();
      m_busy = 0; m_done_next = 0; m_num = 0;
      m_issued = 0; m_ret = 0; m_pop = 0;
      prev_stall = 0;
      RdPortAddrRdy = 1'b0; RdPortDatVld = 1'b0; RdPortDat = '0; OutDatRdy = 1'b0;
    end else begin
      cyc++;
      chk(Done == m_done_next, "done", 64'(Done), 64'(m_done_next));
      if (Done) done_cnt++;
      chk(Busy == m_busy, "busy", 64'(Busy), 64'(m_busy));
      chk(CfgRdy == !m_busy, "cfg_rdy", 64'(CfgRdy), 64'(!m_busy));
      exp_vld = m_busy && (m_issued < m_num) && ((m_issued - m_pop) < DEPTH);
      chk(RdPortAddrVld == exp_vld, "addr_vld", 64'(RdPortAddrVld), 64'(exp_vld));
      if (RdPortAddrVld && exp_vld) begin
        exp_a = AW'(m_base + m_issued * m_stride);
        chk(RdPortAddr == exp_a, "addr", 64'(RdPortAddr), 64'(exp_a));
      end
      if (prev_stall) begin
        chk(RdPortAddrVld == 1'b1, "vld_hold", 64'(RdPortAddrVld), 64'd1);
        chk(RdPortAddr == prev_addr, "addr_stable", 64'(RdPortAddr), 64'(prev_addr));
      end
      chk(OutDatVld == (m_ret > m_pop), "out_vld", 64'(OutDatVld), 64'(m_ret > m_pop));
      chk(RdPortDatRdy == ((m_ret - m_pop) < DEPTH), "dat_rdy", 64'(RdPortDatRdy), 64'((m_ret - m_pop) < DEPTH));
      if (OutDatVld && (m_ret > m_pop)) begin
        exp_d = mk_dat(AW'(m_base + m_pop * m_stride));
        chk(OutDat == exp_d, "out_dat", OutDat[63:0], exp_d[63:0]);
      end

      // Drive this cycle's inputs.
      RdPortAddrRdy = (addr_rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      case (out_rdy_mode)
        1:       OutDatRdy = 1'b0;
        2:       OutDatRdy = 1'($urandom_range(0, 1));
        default: OutDatRdy = 1'b1;
      endcase
      if (glbq.size() > 0 && glbq[0].due <= cyc) begin
        RdPortDatVld = 1'b1;
        RdPortDat    = mk_dat(glbq[0].addr);
        chk(RdPortDatRdy == 1'b1, "fifo_overflow", 64'(RdPortDatRdy), 64'd1);
      end else begin
        RdPortDatVld = 1'b0;
        RdPortDat    = '0;
      end

      // Predict the handshakes of the coming edge and advance the model.
      addr_hs = RdPortAddrVld & RdPortAddrRdy;
      dat_hs  = RdPortDatVld & RdPortDatRdy;
      out_hs  = OutDatVld & OutDatRdy;
      cfg_hs  = CfgVld & CfgRdy;
      m_done_next = 0;
      if (addr_hs) begin
        glbq.push_back('{RdPortAddr, cyc + lat});
        addr_log.push_back(RdPortAddr);
        addr_cyc.push_back(cyc);
        m_issued++;
      end
      if (dat_hs) begin
        void'(glbq.pop_front());
        m_ret++;
      end
      if (out_hs) begin
        m_pop++;
        if (m_busy && m_pop == m_num) begin
          m_busy = 0;
          m_done_next = 1;
        end
      end
      if (cfg_hs) begin
        if (CfgNum == '0) begin
          m_done_next = 1;
        end else begin
          m_busy = 1;
          m_base = int'(CfgBaseAddr); m_stride = int'(CfgStride); m_num = int'(CfgNum);
          m_issued = 0; m_ret = 0; m_pop = 0;
        end
      end
      prev_stall = RdPortAddrVld & ~RdPortAddrRdy;
      prev_addr  = RdPortAddr;
    end
  end

  task automatic run_cfg(input logic [AW-1:0] base, input logic [AW-1:0] stride, input logic [NW-1:0] num);
    @(posedge clk); #2;
    addr_log.delete();
    addr_cyc.delete();
    CfgBaseAddr = base; CfgStride = stride; CfgNum = num; CfgVld = 1'b1;
    for (int i = 0; i < 200 && !CfgRdy; i++) begin
      @(posedge clk); #2;
    end
    chk(CfgRdy == 1'b1, "cfg_accept", 64'(CfgRdy), 64'd1);
    @(posedge clk); #2;
    CfgVld = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    for (int i = 0; i < 3000 && done_cnt == d0; i++) begin
      @(posedge clk); #2;
    end
    repeat (5) @(posedge clk);
    #2;
    chk(done_cnt == d0 + 1, name, 64'(done_cnt), 64'(d0 + 1));
  endtask

  task automatic check_reset_values(input string tag);
    chk(CfgRdy == 1'b1,        {tag, "_cfg_rdy"},  64'(CfgRdy), 64'd1);
    chk(RdPortAddr == '0,      {tag, "_addr"},     64'(RdPortAddr), 64'd0);
    chk(RdPortAddrVld == 1'b0, {tag, "_addr_vld"}, 64'(RdPortAddrVld), 64'd0);
    chk(RdPortDatRdy == 1'b1,  {tag, "_dat_rdy"},  64'(RdPortDatRdy), 64'd1);
    chk(OutDatVld == 1'b0,     {tag, "_out_vld"},  64'(OutDatVld), 64'd0);
    chk(OutDat == '0,          {tag, "_out_dat"},  OutDat[63:0], 64'd0);
    chk(Busy == 1'b0,          {tag, "_busy"},     64'(Busy), 64'd0);
    chk(Done == 1'b0,          {tag, "_done"},     64'(Done), 64'd0);
  endtask

  initial begin
    int d0;
    logic [AW-1:0] b4, s4;
    #3;
    check_reset_values("rst0");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Unit-stride burst with immediate returns.
    salt = 16'h1234; addr_rdy_mode = 0; out_rdy_mode = 0; lat = 1;
    d0 = done_cnt;
    run_cfg(16'h0010, 16'd1, 16'd8);
    wait_done(d0, "t1_done_once");
    chk(addr_log.size() == 8, "t1_count", 64'(addr_log.size()), 64'd8);
    if (addr_log.size() == 8) begin
      chk(addr_log[0] == 16'h0010, "t1_first", 64'(addr_log[0]), 64'h10);
      chk(addr_log[7] == 16'h0017, "t1_last", 64'(addr_log[7]), 64'h17);
      chk(addr_cyc[7] - addr_cyc[0] == 7, "t1_back_to_back", 64'(addr_cyc[7] - addr_cyc[0]), 64'd7);
    end

    // Address wrap.
    salt = 16'hBEEF;
    d0 = done_cnt;
    run_cfg(16'hFFFE, 16'd2, 16'd3);
    wait_done(d0, "t2_done_once");
    chk(addr_log.size() == 3, "t2_count", 64'(addr_log.size()), 64'd3);
    if (addr_log.size() == 3) begin
      chk(addr_log[0] == 16'hFFFE, "t2_a0", 64'(addr_log[0]), 64'hFFFE);
      chk(addr_log[1] == 16'h0000, "t2_a1", 64'(addr_log[1]), 64'h0);
      chk(addr_log[2] == 16'h0002, "t2_a2", 64'(addr_log[2]), 64'h2);
    end

    // Consumer stall: credit caps issue at the buffer depth.
    salt = 16'h0F0F; out_rdy_mode = 1;
    d0 = done_cnt;
    run_cfg(16'h0100, 16'd3, 16'd10);
    repeat (20) @(posedge clk);
    #2;
    chk(addr_log.size() == 4, "t3_stalled_issues", 64'(addr_log.size()), 64'd4);
    chk(RdPortAddrVld == 1'b0, "t3_vld_low", 64'(RdPortAddrVld), 64'd0);
    out_rdy_mode = 0;
    wait_done(d0, "t3_done_once");
    chk(addr_log.size() == 10, "t3_count", 64'(addr_log.size()), 64'd10);

    // Random GLB backpressure, long return latency, random consumer.
    salt = 16'($urandom); addr_rdy_mode = 1; out_rdy_mode = 2; lat = 5;
    b4 = 16'($urandom); s4 = 16'($urandom_range(1, 300));
    d0 = done_cnt;
    run_cfg(b4, s4, 16'd12);
    wait_done(d0, "t4_done_once");
    chk(addr_log.size() == 12, "t4_count", 64'(addr_log.size()), 64'd12);

    // Zero-length configuration.
    addr_rdy_mode = 0; out_rdy_mode = 0; lat = 1;
    d0 = done_cnt;
    run_cfg(16'h0200, 16'd1, 16'd0);
    wait_done(d0, "t5_done_once");
    chk(addr_log.size() == 0, "t5_no_issue", 64'(addr_log.size()), 64'd0);
    chk(CfgRdy == 1'b1, "t5_cfg_rdy", 64'(CfgRdy), 64'd1);

    // Reset in the middle of issue, then a clean run.
    salt = 16'h7777; lat = 3;
    run_cfg(16'h0040, 16'd1, 16'd8);
    for (int i = 0; i < 100 && addr_log.size() < 3; i++) begin
      @(posedge clk); #2;
    end
    chk(addr_log.size() == 3, "t6_issued_before_rst", 64'(addr_log.size()), 64'd3);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst1");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    salt = 16'h2468; lat = 2; out_rdy_mode = 2;
    d0 = done_cnt;
    run_cfg(16'h0200, 16'd5, 16'd6);
    wait_done(d0, "t6_done_once");
    chk(addr_log.size() == 6, "t6_count", 64'(addr_log.size()), 64'd6);
    if (addr_log.size() == 6)
      chk(addr_log[5] == 16'h0219, "t6_last", 64'(addr_log[5]), 64'h219);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
